// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Comm master between NUM_REQ requesters.
// Latches the winner's command, pulses load, follows busy to completion or timeout abort.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int START_TO = 16,
  parameter int XFER_TO  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_two_bytes,
  input  logic [NUM_REQ-1:0]      req_rd_wr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic                    rd_flag,
  output logic                    i2c_load,
  output logic [6:0]              i2c_addr,
  output logic [15:0]             i2c_data,
  output logic                    i2c_numBytes,
  output logic                    i2c_rd_wr,
  input  logic                    i2c_busy,
  input  logic                    i2c_dataReady
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(START_TO + 1);
  localparam int TW = ((XFER_TO > SW) ? XFER_TO : SW) + 1;
  localparam logic [TW-1:0] START_LIM = TW'(START_TO);
  localparam logic [TW-1:0] XFER_LIM  = {{(TW-1){1'b0}}, 1'b1} << XFER_TO;
  localparam logic [PW:0]   NUM_REQ_W = (PW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, r_done, r_err;
  logic [PW-1:0]        r_ptr, r_owner;
  logic                 r_load, r_rd_flag, r_acc;
  logic [6:0]           r_addr;
  logic [15:0]          r_data;
  logic                 r_two, r_rd;
  logic [TW-1:0]        r_tmr, w_tmr_inc;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [PW-1:0]        w_ofs, w_pick;
  logic [PW:0]          w_sum;
  logic                 w_found;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [6:0]           w_addr;
  logic [15:0]          w_data;
  logic                 w_two, w_rd;

  // Rotating the doubled request vector by the pointer makes bit k mean "requester ptr+k".
  assign w_dbl     = {req, req} >> r_ptr;
  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_ofs};
  assign w_pick    = (w_sum >= NUM_REQ_W) ? (w_sum[PW-1:0] - NUM_REQ_W[PW-1:0]) : w_sum[PW-1:0];
  assign w_pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_tmr_inc = r_tmr + TW'(1);

  // Round-robin search and command field mux for the winning requester
  always_comb begin
    w_found = 1'b0;
    w_ofs   = '0;
    w_addr  = 7'd0;
    w_data  = 16'd0;
    w_two   = 1'b0;
    w_rd    = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_dbl[k]) begin
        w_found = 1'b1;
        w_ofs   = PW'(k);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == PW'(i)) begin
        w_addr = req_addr[7*i +: 7];
        w_data = req_data[16*i +: 16];
        w_two  = req_two_bytes[i];
        w_rd   = req_rd_wr[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found && !i2c_busy) w_state_nxt = S_ISSUE;
        else                      w_state_nxt = S_IDLE;
      end
      S_ISSUE: w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i2c_busy)                    w_state_nxt = S_RUN;
        else if (w_tmr_inc == START_LIM) w_state_nxt = S_ABORT;
        else                             w_state_nxt = S_WAIT_BUSY;
      end
      S_RUN: begin
        if (!i2c_busy)                  w_state_nxt = S_DONE;
        else if (w_tmr_inc == XFER_LIM) w_state_nxt = S_ABORT;
        else                            w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered outputs, latched command, timer and dataReady accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_load    <= 1'b0;
      r_rd_flag <= 1'b0;
      r_acc     <= 1'b0;
      r_addr    <= 7'd0;
      r_data    <= 16'd0;
      r_two     <= 1'b0;
      r_rd      <= 1'b0;
      r_tmr     <= '0;
    end else begin
      r_load <= (r_state == S_ISSUE);
      r_done <= (w_state_nxt == S_DONE)  ? r_grant : '0;
      r_err  <= (w_state_nxt == S_ABORT) ? r_grant : '0;
      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_ISSUE) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_two   <= w_two;
            r_rd    <= w_rd;
          end
        end
        S_ISSUE: begin
          r_tmr     <= '0;
          r_acc     <= 1'b0;
          r_rd_flag <= 1'b0;
        end
        S_WAIT_BUSY: r_tmr <= i2c_busy ? '0 : w_tmr_inc;
        S_RUN: begin
          r_tmr <= w_tmr_inc;
          r_acc <= r_acc | i2c_dataReady;
          if (!i2c_busy) r_rd_flag <= r_acc | i2c_dataReady;
        end
        S_DONE, S_ABORT: begin
          r_grant <= '0;
          r_ptr   <= (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + PW'(1);
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign err          = r_err;
  assign rd_flag      = r_rd_flag;
  assign i2c_load     = r_load;
  assign i2c_addr     = r_addr;
  assign i2c_data     = r_data;
  assign i2c_numBytes = r_two;
  assign i2c_rd_wr    = r_rd;
endmodule
